// File: rtl/fir_axilite_cfg.sv
// ============================================================================
//  Module      : fir_axilite_cfg
//  Description : AXI-Lite configuration slave for the FIR block. Holds the
//                ap_ctrl and data_length registers, gives the host a path
//                into the tap coefficient BRAM, issues ap_start to the FIR
//                engine and tracks ap_done / ap_idle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    axis_clk, axis_rst_n       clock, synchronous active-low reset
//    aw*/w*                     AXI-Lite write address / data (no B channel)
//    ar*/r*                     AXI-Lite read address / data
//    ap_start_o                 one-cycle start pulse to the engine
//    eng_done_i                 one-cycle pulse, engine finished
//    data_length_o              programmed sample count
//    eng_tap_A                  engine tap read address (owns port when busy)
//    tap_WE/EN/Di/A, tap_Do     tap BRAM port (1-cycle read latency)
// ============================================================================
`default_nettype none

module fir_axilite_cfg #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rvalid,
    input  logic                   rready,
    output logic                   ap_start_o,
    input  logic                   eng_done_i,
    output logic [pDATA_WIDTH-1:0] data_length_o,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do
);

    localparam logic [pADDR_WIDTH-1:0] c_ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] c_ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] c_TAP_BASE  = pADDR_WIDTH'(64);
    localparam logic [pADDR_WIDTH-1:0] c_TAP_END   = pADDR_WIDTH'(64 + 4 * Tape_Num);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    rd_state_t r_rd_state;
    rd_state_t w_rd_state_nxt;

    logic                   r_aw_full;
    logic                   r_w_full;
    logic [pADDR_WIDTH-1:0] r_awaddr;
    logic [pDATA_WIDTH-1:0] r_wdata;
    logic [pADDR_WIDTH-1:0] r_araddr;
    logic [pDATA_WIDTH-1:0] r_rdata;
    logic                   r_rd_from_bram;
    logic                   r_ap_start;
    logic                   r_ap_done;
    logic                   r_ap_idle;
    logic [pDATA_WIDTH-1:0] r_data_length;

    logic                   w_commit;
    logic                   w_wr_tap;
    logic                   w_start;
    logic                   w_rd_tap;
    logic                   w_rd_collide;
    logic                   w_ctrl_rd;
    logic [pDATA_WIDTH-1:0] w_reg_rdata;

    // Only word-aligned addresses inside the coefficient window are taps.
    function automatic logic f_is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= c_TAP_BASE) && (a < c_TAP_END) && (a[1:0] == 2'b00);
    endfunction

    assign w_commit     = r_aw_full && r_w_full;
    assign w_wr_tap     = w_commit && f_is_tap(r_awaddr);
    assign w_start      = w_commit && (r_awaddr == c_ADDR_CTRL) && r_wdata[0] && r_ap_idle;
    assign w_rd_tap     = (r_rd_state == R_ADDR) && f_is_tap(r_araddr);
    // A host tap write and a host tap read cannot share the single BRAM port;
    // the write goes first and the read address phase repeats.
    assign w_rd_collide = w_rd_tap && r_ap_idle && w_wr_tap;
    assign w_ctrl_rd    = (r_rd_state == R_ADDR) && (r_araddr == c_ADDR_CTRL);

    assign awready       = !r_aw_full;
    assign wready        = !r_w_full;
    assign ap_start_o    = r_ap_start;
    assign data_length_o = r_data_length;
    // The BRAM output is valid during the first R_DATA cycle and is captured
    // at its end, so rdata stays stable for as long as rready is held low.
    assign rdata         = r_rd_from_bram ? tap_Do : r_rdata;

    // ---------------- write address / data latches ----------------
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
        end else if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else begin
            if (!r_aw_full && awvalid) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= awaddr;
            end
            if (!r_w_full && wvalid) begin
                r_w_full <= 1'b1;
                r_wdata  <= wdata;
            end
        end
    end

    // ---------------- control / length registers ----------------
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_ap_start    <= 1'b0;
            r_ap_done     <= 1'b0;
            r_ap_idle     <= 1'b1;
            r_data_length <= '0;
        end else begin
            r_ap_start <= w_start;
            if (w_start) begin
                r_ap_idle <= 1'b0;
                r_ap_done <= 1'b0;
            end else if (eng_done_i) begin
                r_ap_done <= 1'b1;
                r_ap_idle <= 1'b1;
            end else if (w_ctrl_rd) begin
                r_ap_done <= 1'b0;
            end
            if (w_commit && (r_awaddr == c_ADDR_LEN) && r_ap_idle) begin
                r_data_length <= r_wdata;
            end
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        arready        = 1'b0;
        rvalid         = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) w_rd_state_nxt = R_ADDR;
            end
            R_ADDR: begin
                if (!w_rd_collide) w_rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) w_rd_state_nxt = R_IDLE;
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_reg_rdata = '0;
        if (r_araddr == c_ADDR_CTRL) begin
            w_reg_rdata = {{(pDATA_WIDTH-3){1'b0}}, r_ap_idle, r_ap_done, r_ap_start};
        end else if (r_araddr == c_ADDR_LEN) begin
            w_reg_rdata = r_data_length;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_araddr       <= '0;
            r_rdata        <= '0;
            r_rd_from_bram <= 1'b0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (arvalid) r_araddr <= araddr;
                end
                R_ADDR: begin
                    if (!w_rd_collide) begin
                        if (w_rd_tap) begin
                            if (r_ap_idle) r_rd_from_bram <= 1'b1;
                            else           r_rdata        <= '1;
                        end else begin
                            r_rdata <= w_reg_rdata;
                        end
                    end
                end
                R_DATA: begin
                    if (r_rd_from_bram) begin
                        r_rdata        <= tap_Do;
                        r_rd_from_bram <= 1'b0;
                    end
                end
                default: r_rd_from_bram <= 1'b0;
            endcase
        end
    end

    // ---------------- tap BRAM port mux ----------------
    always_comb begin
        tap_WE = 4'h0;
        tap_EN = 1'b0;
        tap_Di = '0;
        tap_A  = '0;
        if (!r_ap_idle) begin
            tap_A  = eng_tap_A;
            tap_EN = 1'b1;
        end else if (w_wr_tap) begin
            tap_A  = r_awaddr - c_TAP_BASE;
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_Di = r_wdata;
        end else if (w_rd_tap) begin
            tap_A  = r_araddr - c_TAP_BASE;
            tap_EN = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_axilite_cfg.sv
// ============================================================================
//  Module      : tb_fir_axilite_cfg
//  Description : Self-checking bench for fir_axilite_cfg. A behavioural
//                register/tap model predicts every read and the per-cycle
//                state of data_length_o, ap_start_o and the engine tap port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_axilite_cfg;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic [11:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [11:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        ap_start_o;
    logic        eng_done_i = 1'b0;
    logic [31:0] data_length_o;
    logic [11:0] eng_tap_A = '0;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [31:0] tap_Di;
    logic [11:0] tap_A;
    logic [31:0] tap_Do;

    fir_axilite_cfg #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .ap_start_o(ap_start_o), .eng_done_i(eng_done_i),
        .data_length_o(data_length_o), .eng_tap_A(eng_tap_A),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A),
        .tap_Do(tap_Do)
    );

    always #5 axis_clk = ~axis_clk;

    // Tap BRAM: 1-cycle read latency.
    logic [31:0] bram [0:1023];
    initial for (int i = 0; i < 1024; i++) bram[i] = '0;
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) bram[tap_A[11:2]] <= tap_Di;
            tap_Do <= bram[tap_A[11:2]];
        end
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_tap [0:10];
    logic [31:0] m_len   = '0;
    logic        m_idle  = 1'b1;
    logic        m_done  = 1'b0;
    logic        m_start = 1'b0;
    int          m_we_exp = 0;
    int          m_starts = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int we_seen  = 0;
    int starts_seen = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_is_tap(input logic [11:0] a);
        int ai;
        ai = int'(a);
        return (ai >= 64) && (ai < 64 + 4 * 11) && (ai % 4 == 0);
    endfunction

    function automatic int m_idx(input logic [11:0] a);
        return (int'(a) - 64) / 4;
    endfunction

    // Expected read value; reading ap_ctrl clears done.
    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] v;
        v = '0;
        if (a == 12'h000) begin
            v = {29'b0, m_idle, m_done, 1'b0};
            m_done = 1'b0;
        end else if (a == 12'h010) begin
            v = m_len;
        end else if (m_is_tap(a)) begin
            v = m_idle ? m_tap[m_idx(a)] : 32'hFFFF_FFFF;
        end
        return v;
    endfunction

    // Engine address stream, changes every cycle.
    initial forever begin
        @(posedge axis_clk); #1;
        eng_tap_A = 12'($urandom_range(0, 10) * 4);
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge axis_clk);
        if (mon_en) begin
            check("data_length_o", data_length_o, m_len);
            check("ap_start_o", 32'(ap_start_o), 32'(m_start));
            if (!m_idle) begin
                check("busy_tap_A", 32'(tap_A), 32'(eng_tap_A));
                check("busy_tap_EN", 32'(tap_EN), 32'd1);
                check("busy_tap_WE", 32'(tap_WE), 32'd0);
            end
            if (tap_WE == 4'hF) we_seen++;
            if (ap_start_o) starts_seen++;
        end
    end

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             input int aw_dly, input int w_dly);
        fork
            begin
                int k;
                repeat (aw_dly) begin @(posedge axis_clk); #1; end
                awaddr = a; awvalid = 1'b1; k = 0;
                while (!awready && k < 50) begin @(posedge axis_clk); #1; k++; end
                if (k >= 50) check("aw_timeout", 32'd0, 32'd1);
                @(posedge axis_clk); #1;
                awvalid = 1'b0;
            end
            begin
                int k;
                repeat (w_dly) begin @(posedge axis_clk); #1; end
                wdata = d; wvalid = 1'b1; k = 0;
                while (!wready && k < 50) begin @(posedge axis_clk); #1; k++; end
                if (k >= 50) check("w_timeout", 32'd0, 32'd1);
                @(posedge axis_clk); #1;
                wvalid = 1'b0;
            end
        join
        // commit cycle; the write takes effect at the next edge
        @(posedge axis_clk); #1;
        if (a == 12'h000) begin
            if (d[0] && m_idle) begin
                m_idle = 1'b0; m_done = 1'b0; m_start = 1'b1; m_starts++;
                @(posedge axis_clk); #1;
                m_start = 1'b0;
            end
        end else if (m_idle) begin
            if (a == 12'h010) m_len = d;
            else if (m_is_tap(a)) begin
                m_tap[m_idx(a)] = d;
                m_we_exp++;
            end
        end
    endtask

    task automatic axi_read(input logic [11:0] a, input int hold, output logic [31:0] d);
        int k;
        araddr = a; arvalid = 1'b1; k = 0;
        while (!arready && k < 50) begin @(posedge axis_clk); #1; k++; end
        if (k >= 50) check("ar_timeout", 32'd0, 32'd1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0; k = 0;
        while (!rvalid && k < 50) begin @(posedge axis_clk); #1; k++; end
        if (k >= 50) check("rvalid_timeout", 32'd0, 32'd1);
        d = rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge axis_clk); #1;
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, d);
        end
        rready = 1'b1;
        @(posedge axis_clk); #1;
        rready = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input int hold);
        logic [31:0] exp, got;
        exp = m_read(a);
        axi_read(a, hold, got);
        check(name, got, exp);
    endtask

    function automatic logic [11:0] pick_addr();
        logic [11:0] junk [0:5];
        junk[0] = 12'h004; junk[1] = 12'h020; junk[2] = 12'h042;
        junk[3] = 12'h06C; junk[4] = 12'h03C; junk[5] = 12'h800;
        case ($urandom_range(0, 5))
            0:       return 12'h000;
            1:       return 12'h010;
            2, 3:    return 12'(64 + 4 * $urandom_range(0, 10));
            4:       return junk[$urandom_range(0, 5)];
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    // ---------------- test sequence ----------------
    logic [31:0] coef [0:10];
    logic [31:0] got;

    initial begin
        coef[0] = 32'd0;   coef[1] = -32'sd10; coef[2] = -32'sd9; coef[3] = 32'd23;
        coef[4] = 32'd56;  coef[5] = 32'd63;   coef[6] = 32'd56;  coef[7] = 32'd23;
        coef[8] = -32'sd9; coef[9] = -32'sd10; coef[10] = 32'd0;
        for (int i = 0; i < 11; i++) m_tap[i] = '0;

        // reset values
        repeat (3) begin @(posedge axis_clk); #1; end
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ap_start", 32'(ap_start_o), 32'd0);
        check("rst_data_length", data_length_o, 32'd0);
        check("rst_tap_WE", 32'(tap_WE), 32'd0);
        check("rst_tap_EN", 32'(tap_EN), 32'd0);
        axis_rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge axis_clk); #1;

        axi_read(12'h000, 0, got);
        check("ctrl_after_reset", got, 32'h4);
        m_done = 1'b0;

        // configuration and full readback
        we_seen = 0;
        axi_write(12'h010, 32'd600, 0, 0);
        for (int i = 0; i < 11; i++) axi_write(12'(64 + 4 * i), coef[i], 0, 0);
        check("tap_we_count", 32'(we_seen), 32'd11);
        read_check("len_readback", 12'h010, 0);
        check("len_literal", data_length_o, 32'd600);
        for (int i = 0; i < 11; i++) read_check("tap_readback", 12'(64 + 4 * i), 0);

        // channel ordering
        axi_write(12'h044, 32'd7, 0, 0);
        axi_write(12'h044, -32'sd10, 0, 3);
        axi_read(12'h044, 0, got); check("aw_first", got, -32'sd10);
        axi_write(12'h044, 32'd5, 0, 0);
        axi_write(12'h044, -32'sd10, 2, 0);
        axi_read(12'h044, 0, got); check("w_first", got, -32'sd10);
        axi_write(12'h044, 32'd3, 0, 0);
        axi_write(12'h044, -32'sd10, 0, 0);
        axi_read(12'h044, 0, got); check("same_cycle", got, -32'sd10);

        // write/read collision on the tap port
        for (int n = 0; n < 4; n++) begin
            int wi, ri;
            logic [31:0] wd;
            wi = $urandom_range(0, 10);
            ri = (wi + 1 + $urandom_range(0, 9)) % 11;
            wd = $urandom;
            fork
                axi_write(12'(64 + 4 * wi), wd, 0, 0);
                read_check("collide_read", 12'(64 + 4 * ri), 0);
            join
            read_check("collide_write", 12'(64 + 4 * wi), 0);
        end
        for (int i = 0; i < 11; i++) axi_write(12'(64 + 4 * i), coef[i], 0, 0);

        // start and busy behaviour
        axi_write(12'h000, 32'h1, 0, 0);
        read_check("ctrl_busy", 12'h000, 0);
        axi_write(12'h048, 32'd99, 0, 0);
        axi_write(12'h010, 32'd1234, 0, 0);
        axi_write(12'h000, 32'h1, 0, 0);
        axi_read(12'h04C, 0, got); check("busy_tap_read", got, 32'hFFFF_FFFF);
        read_check("busy_len_read", 12'h010, 2);

        // engine done
        eng_done_i = 1'b1;
        @(posedge axis_clk); #1;
        eng_done_i = 1'b0;
        m_done = 1'b1; m_idle = 1'b1;
        axi_read(12'h000, 0, got); check("ctrl_done", got, 32'h6);
        axi_read(12'h000, 0, got); check("ctrl_done_cleared", got, 32'h4);
        m_done = 1'b0;
        axi_read(12'h048, 0, got); check("tap_busy_write_dropped", got, -32'sd9);
        read_check("len_busy_write_dropped", 12'h010, 0);

        // randomized traffic while idle
        for (int n = 0; n < 60; n++) begin
            logic [11:0] a;
            logic [31:0] d;
            a = pick_addr();
            d = $urandom;
            if (a == 12'h000) d[0] = 1'b0;
            if ($urandom_range(0, 1) == 0)
                axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3));
            else
                read_check("rand_read", a, $urandom_range(0, 3));
        end

        // rready held low
        read_check("hold_read", 12'h054, 5);

        // reset during R_DATA
        araddr = 12'h010; arvalid = 1'b1;
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        @(posedge axis_clk); #1;
        check("pre_reset_rvalid", 32'(rvalid), 32'd1);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b0;
        @(posedge axis_clk); #1;
        m_len = '0; m_idle = 1'b1; m_done = 1'b0; m_start = 1'b0;
        check("midreset_rvalid", 32'(rvalid), 32'd0);
        check("midreset_arready", 32'(arready), 32'd1);
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;
        read_check("ctrl_after_midreset", 12'h000, 0);

        check("we_total", 32'(we_seen), 32'(m_we_exp));
        check("start_total", 32'(starts_seen), 32'(m_starts));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/fir_axilite_cfg.md
Name: fir_axilite_cfg

Overview:
- AXI-Lite configuration slave in front of the FIR datapath.
- Owns the ap_ctrl register and the data_length register, and is the host path into the tap coefficient BRAM (bram11, 11 words).
- Issues ap_start to the FIR engine and tracks ap_done/ap_idle.
- While the engine runs, the engine owns the tap BRAM port; host tap accesses are blocked.

Parameters:
pADDR_WIDTH, 12, AXI-Lite and BRAM address width (byte address)
pDATA_WIDTH, 32, data width
Tape_Num, 11, number of tap coefficients

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  reset; synchronous, active-low
awaddr  in  pADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  pDATA_WIDTH  write data
wvalid  in  1  write data valid
wready  out  1  write data ready
araddr  in  pADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  pDATA_WIDTH  read data
rvalid  out  1  read data valid
rready  in  1  read data ready
ap_start_o  out  1  one-cycle start pulse to the FIR engine
eng_done_i  in  1  one-cycle pulse: engine produced the last sample
data_length_o  out  pDATA_WIDTH  programmed length
eng_tap_A  in  pADDR_WIDTH  engine tap read address (byte address)
tap_WE  out  4  tap BRAM byte write enables
tap_EN  out  1  tap BRAM enable
tap_Di  out  pDATA_WIDTH  tap BRAM write data
tap_A  out  pADDR_WIDTH  tap BRAM address
tap_Do  in  pDATA_WIDTH  tap BRAM read data, 1-cycle latency

Behaviour:
- Reset (axis_rst_n=0 at posedge): awready=1, wready=1, arready=1, rvalid=0, rdata=0, ap_start_o=0, ap_done=0, ap_idle=1, data_length=0, tap_WE=0, tap_EN=0.
- Register map:
  - 0x00 ap_ctrl: bit0 ap_start (W1, self-clearing, reads 1 only in the cycle it is set); bit1 ap_done (RO, cleared by a read of 0x00); bit2 ap_idle (RO).
  - 0x10 data_length (RW).
  - 0x40+4k for k=0..10: tap[k], stored in tap BRAM at address 4k.
  - Other addresses: writes dropped, reads return 0.
- Write channel:
  - AW and W are independent. awready=1 while no address is latched; wready=1 while no data is latched. Either may arrive first or both in the same cycle.
  - The cycle after both are latched, commit the write: one cycle, tap_EN=1, tap_WE=4'hF for tap addresses. Then clear both latches, so awready/wready return to 1 on the following cycle.
  - No B channel.
- Write rules:
  - Writing 0x00 with bit0=1 while ap_idle=1: pulse ap_start_o for 1 cycle, set ap_idle=0, clear ap_done.
  - ap_start write while busy: ignored.
  - Writes to 0x10 or taps while ap_idle=0: dropped; handshake still completes.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On arvalid, latch araddr and go to R_ADDR.
  - R_ADDR: drive tap_A/tap_EN for a tap address; go to R_DATA.
  - R_DATA: rvalid=1, rdata holds tap_Do (captured) or the register value. Stay until rready=1, then R_IDLE.
- Tap reads while ap_idle=0 return 32'hFFFF_FFFF and do not touch the BRAM.
- Engine done: on eng_done_i, ap_done=1 and ap_idle=1 in the next cycle.
- Tap BRAM port mux:
  - ap_idle=0: tap_A=eng_tap_A, tap_EN=1, tap_WE=0.
  - Otherwise the host owns the port.
  - If a host write commit and a host tap read collide in the same cycle, the write wins and the read's R_ADDR is retried next cycle.
- data_length_o always reflects the register.
- Reset mid-transaction aborts the transaction: latches are cleared, rvalid=0, the engine is considered idle.

Test Plan:
- Reset, then read 0x00 -> rdata=0x4 (idle=1, done=0).
- Write 0x10=600, taps -> {0,-10,-9,23,56,63,56,23,-9,-10,0}; read back all 12 -> exact values, tap_WE=4'hF seen 11 times.
- AW before W by 3 cycles, W before AW by 2 cycles, and both same cycle, each to 0x44 = -10 -> readback -10 in all three cases.
- Write 0x00=1 -> ap_start_o high exactly 1 cycle; then read 0x00 -> idle=0. Write tap 0x48=99 while busy -> readback after done still -9. Tap read while busy -> 0xFFFFFFFF.
- Pulse eng_done_i -> read 0x00 = 0x6, second read = 0x4.
- Hold rready=0 for 5 cycles in R_DATA -> rvalid and rdata stable throughout. Assert reset mid-read -> rvalid=0 and arready=1 next cycle.
